// File: rtl/counter_if.sv
// Purpose : groups the counter's direction input and registered count output.
// Latency : none (plain wires between the driver and the counter).
// Backpressure: none; the counter steps every cycle with no handshake.
// Ports/signals:
//   mode : 1 = count up, 0 = count down (driven by master)
//   cnt  : signed 10-bit registered count (driven by slave)
interface counter_if;
    logic              mode;
    logic signed [9:0] cnt;

    modport master (output mode, input cnt);
    modport slave  (input mode, output cnt);
endinterface

// File: rtl/counter_core.sv
// Purpose : signed up(+5)/down(-9) counter that never takes the value -11
//           and saturates to the range -230..235.
// Latency : one cycle from rst/mode to cnt.
// Backpressure: none; a new step is taken on every clock edge.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset, loads -50
//   bus : counter_if.slave (mode in, cnt out)
module counter_core (
    input  logic      clk,
    input  logic      rst,
    counter_if.slave  bus
);

    localparam logic signed [9:0]  CNT_RST   = -10'sd50;
    localparam logic signed [10:0] CNT_MAX   = 11'sd235;
    localparam logic signed [10:0] CNT_MIN   = -11'sd230;
    // These two start points are the only ones whose normal step lands on -11,
    // so they take a double step to jump over it.
    localparam logic signed [10:0] UP_SKIP   = -11'sd16;
    localparam logic signed [10:0] DN_SKIP   = -11'sd2;

    logic signed [9:0]  cnt_q;
    logic signed [9:0]  cnt_d;
    logic signed [10:0] cur_w;
    logic signed [10:0] step_w;
    logic signed [10:0] sum_w;

    // 11-bit intermediates: the widest excursion (-230 - 18 = -248, 235 + 10)
    // stays well inside range, so the clamp sees the true value before any
    // truncation back to 10 bits.
    always_comb begin
        cur_w  = {cnt_q[9], cnt_q};
        step_w = 11'sd0;
        sum_w  = cur_w;
        if (bus.mode) begin
            step_w = (cur_w == UP_SKIP) ? 11'sd10 : 11'sd5;
            sum_w  = cur_w + step_w;
            if (sum_w > CNT_MAX) begin
                sum_w = CNT_MAX;
            end
        end else begin
            step_w = (cur_w == DN_SKIP) ? 11'sd18 : 11'sd9;
            sum_w  = cur_w - step_w;
            if (sum_w < CNT_MIN) begin
                sum_w = CNT_MIN;
            end
        end
        cnt_d = 10'(sum_w);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= CNT_RST;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bus.cnt = cnt_q;

endmodule

// File: tb/tb_counter_core.sv
module tb_counter_core;

    logic clk;
    logic rst;
    counter_if bus ();

    counter_core dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp;
    int n_err;
    int model_cnt;

    // Reference: next count from the plain arithmetic rules.
    function automatic int ref_next(int c, bit r, bit m);
        int n;
        if (r) return -50;
        if (m) begin
            n = (c == -16) ? c + 10 : c + 5;
            if (n > 235) n = 235;
        end else begin
            n = (c == -2) ? c - 18 : c - 9;
            if (n < -230) n = -230;
        end
        return n;
    endfunction

    // Drive one edge worth of inputs, advance, update the model.
    task automatic step(input bit r, input bit m);
        rst      = r;
        bus.mode = m;
        @(posedge clk);
        #1;
        model_cnt = ref_next(model_cnt, r, m);
    endtask

    task automatic test_reset;
        int exp_up[3];
        exp_up = '{-45, -40, -35};
        step(1'b1, 1'($urandom_range(1)));
        n_cmp++;
        if (bus.cnt !== -10'sd50) begin
            n_err++;
            $display("FAIL reset_load: cnt=%0d expected=-50", bus.cnt);
        end
        step(1'b1, 1'($urandom_range(1)));
        n_cmp++;
        if (bus.cnt !== -10'sd50) begin
            n_err++;
            $display("FAIL reset_hold: cnt=%0d expected=-50", bus.cnt);
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1);
            n_cmp++;
            if (bus.cnt !== 10'(exp_up[i])) begin
                n_err++;
                $display("FAIL reset_resume[%0d]: cnt=%0d expected=%0d", i, bus.cnt, exp_up[i]);
            end
        end
    endtask

    task automatic test_down_skip;
        int exp_dn[5];
        exp_dn = '{16, 7, -2, -20, -29};
        step(1'b1, 1'b0);
        for (int i = 0; i < 15; i++) step(1'b0, 1'b1);
        n_cmp++;
        if (bus.cnt !== 10'sd25) begin
            n_err++;
            $display("FAIL down_skip_start: cnt=%0d expected=25", bus.cnt);
        end
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0);
            n_cmp++;
            if (bus.cnt !== 10'(exp_dn[i])) begin
                n_err++;
                $display("FAIL down_skip[%0d]: cnt=%0d expected=%0d", i, bus.cnt, exp_dn[i]);
            end
        end
    endtask

    task automatic test_up_skip;
        int exp_dn[4];
        int exp_up[2];
        exp_dn = '{11, 2, -7, -16};
        exp_up = '{-6, -1};
        step(1'b1, 1'b1);
        for (int i = 0; i < 14; i++) step(1'b0, 1'b1);
        n_cmp++;
        if (bus.cnt !== 10'sd20) begin
            n_err++;
            $display("FAIL up_skip_start: cnt=%0d expected=20", bus.cnt);
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0);
            n_cmp++;
            if (bus.cnt !== 10'(exp_dn[i])) begin
                n_err++;
                $display("FAIL up_skip_dn[%0d]: cnt=%0d expected=%0d", i, bus.cnt, exp_dn[i]);
            end
        end
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b1);
            n_cmp++;
            if (bus.cnt !== 10'(exp_up[i])) begin
                n_err++;
                $display("FAIL up_skip_up[%0d]: cnt=%0d expected=%0d", i, bus.cnt, exp_up[i]);
            end
        end
    endtask

    task automatic test_saturation;
        step(1'b1, 1'b0);
        model_cnt = -50;
        for (int i = 0; i < 70; i++) begin
            step(1'b0, 1'b1);
            n_cmp++;
            if (bus.cnt !== 10'(model_cnt)) begin
                n_err++;
                $display("FAIL sat_up[%0d]: cnt=%0d expected=%0d", i, bus.cnt, model_cnt);
            end
        end
        n_cmp++;
        if (bus.cnt !== 10'sd235) begin
            n_err++;
            $display("FAIL sat_top: cnt=%0d expected=235", bus.cnt);
        end
        step(1'b0, 1'b0);
        n_cmp++;
        if (bus.cnt !== 10'sd226) begin
            n_err++;
            $display("FAIL sat_leave_top: cnt=%0d expected=226", bus.cnt);
        end
        for (int i = 0; i < 70; i++) begin
            step(1'b0, 1'b0);
            n_cmp++;
            if (bus.cnt !== 10'(model_cnt)) begin
                n_err++;
                $display("FAIL sat_dn[%0d]: cnt=%0d expected=%0d", i, bus.cnt, model_cnt);
            end
        end
        n_cmp++;
        if (bus.cnt !== -10'sd230) begin
            n_err++;
            $display("FAIL sat_bottom: cnt=%0d expected=-230", bus.cnt);
        end
        step(1'b0, 1'b1);
        n_cmp++;
        if (bus.cnt !== -10'sd225) begin
            n_err++;
            $display("FAIL sat_leave_bottom: cnt=%0d expected=-225", bus.cnt);
        end
    endtask

    task automatic test_mid_reset;
        bit m;
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < int'($urandom_range(25, 3)); i++)
                step(1'b0, 1'($urandom_range(1)));
            m = 1'($urandom_range(1));
            step(1'b1, m);
            n_cmp++;
            if (bus.cnt !== -10'sd50) begin
                n_err++;
                $display("FAIL mid_reset[%0d]: cnt=%0d expected=-50", k, bus.cnt);
            end
            step(1'b0, m);
            n_cmp++;
            if (bus.cnt !== 10'(m ? -45 : -59)) begin
                n_err++;
                $display("FAIL mid_reset_resume[%0d]: cnt=%0d expected=%0d", k, bus.cnt, m ? -45 : -59);
            end
        end
    endtask

    task automatic test_random;
        int  prev;
        int  cur;
        int  d;
        bit  r;
        bit  was_rst;
        was_rst = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            prev = int'(bus.cnt);
            r    = ($urandom_range(31) == 0);
            // Long runs in one direction so both bounds get exercised.
            if ($urandom_range(15) == 0) bus.mode = ~bus.mode;
            step(r, bus.mode);
            cur = int'(bus.cnt);
            n_cmp++;
            if (bus.cnt !== 10'(model_cnt)) begin
                n_err++;
                $display("FAIL rand_model[%0d]: cnt=%0d expected=%0d", i, bus.cnt, model_cnt);
            end
            n_cmp++;
            if (cur < -230 || cur > 235 || cur == -11) begin
                n_err++;
                $display("FAIL rand_range[%0d]: cnt=%0d expected within -230..235 and not -11", i, cur);
            end
            d = cur - prev;
            if (!r && !was_rst && cur != 235 && cur != -230) begin
                n_cmp++;
                if (d != 5 && d != 10 && d != -9 && d != -18) begin
                    n_err++;
                    $display("FAIL rand_delta[%0d]: delta=%0d expected one of 5,10,-9,-18", i, d);
                end
            end
            was_rst = 1'b0;
        end
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        model_cnt = -50;
        rst       = 1'b1;
        bus.mode  = 1'b0;
        test_reset();
        test_down_skip();
        test_up_skip();
        test_saturation();
        test_mid_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
